// File: rtl/memory_reader_pkg.sv
// Shared definitions for the program-memory access blocks.
//
// Used by memory_reader, memory_programmer and the top-level port mux that
// chooses which block owns the program-memory port.
//
// Contents:
//   DEFAULT_ADRS_WIDTH / DEFAULT_DATA_WIDTH - default memory geometry
//   mem_state_e   - sequencing states shared by the access blocks
//   port_owner_e  - select values for the memory-port mux
package memory_reader_pkg;

    localparam int DEFAULT_ADRS_WIDTH = 8;
    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } mem_state_e;

    typedef enum logic {
        PROG = 1'b0,
        READ = 1'b1
    } port_owner_e;

endpackage

// File: rtl/memory_reader.sv
// memory_reader: walks an address range of the program memory and presents
// each byte, with its address, on a valid/ready stream.
//
// Ports:
//   reset_N     - asynchronous, active-low reset
//   prog_clock  - block clock, all state changes on its rising edge
//   start       - begins a sweep when idle (start_adrs/last_adrs sampled here)
//   abort       - cancels a sweep in progress, no done pulse
//   start_adrs  - first address read
//   last_adrs   - final address read (sweep wraps past the top if below start)
//   busy        - high from accepted start until back in IDLE
//   done        - one-cycle pulse after the last byte is accepted
//   out_valid   - out_adrs/out_data hold a byte
//   out_ready   - downstream accepts the byte
//   out_adrs    - address of the presented byte
//   out_data    - byte read from memory
//   pr_clock    - memory clock, inverted prog_clock
//   pr_wr_en    - memory write enable, always low for this block
//   pr_adrs     - registered read address
//   mm_data     - memory read data
module memory_reader
    import memory_reader_pkg::*;
#(
    parameter int ADRS_WIDTH   = DEFAULT_ADRS_WIDTH,
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int READ_LATENCY = 1
) (
    input  logic                  reset_N,
    input  logic                  prog_clock,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADRS_WIDTH-1:0] start_adrs,
    input  logic [ADRS_WIDTH-1:0] last_adrs,
    output logic                  busy,
    output logic                  done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADRS_WIDTH-1:0] out_adrs,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  pr_clock,
    output logic                  pr_wr_en,
    output logic [ADRS_WIDTH-1:0] pr_adrs,
    input  logic [DATA_WIDTH-1:0] mm_data
);

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_WAIT = 2'(WAIT);
    localparam logic [1:0] S_OUT  = 2'(OUT);
    localparam logic [1:0] S_DONE = 2'(DONE);

    localparam logic [2:0] LATENCY = 3'(READ_LATENCY);
    localparam logic [ADRS_WIDTH-1:0] ADRS_ONE = ADRS_WIDTH'(1);

    logic [1:0]            r_state;
    logic [2:0]            r_cnt;
    logic [ADRS_WIDTH-1:0] r_prAdrs;
    logic [ADRS_WIDTH-1:0] r_lastAdrs;
    logic                  r_outValid;
    logic [ADRS_WIDTH-1:0] r_outAdrs;
    logic [DATA_WIDTH-1:0] r_outData;

    // The memory samples the address on the falling edge of prog_clock, so
    // the address registered on a rising edge is settled by then. The write
    // enable is tied low so the top-level mux can hand the port to us safely.
    assign pr_clock = ~prog_clock;
    assign pr_wr_en = 1'b0;
    assign pr_adrs  = r_prAdrs;

    // busy and done are pure state decodes so they fall together with the
    // state register on abort or reset.
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign out_valid = r_outValid;
    assign out_adrs  = r_outAdrs;
    assign out_data  = r_outData;

    // Sweep sequencer. Each address goes WAIT (count down the memory read
    // latency) -> OUT (hold the byte until accepted) and either advances to
    // the next address or finishes through DONE. Abort wins over everything,
    // including a handshake in the same cycle. The address increment wraps
    // naturally at the top of the address space, which is what lets a
    // last_adrs below start_adrs sweep across the FF->00 boundary.
    always_ff @(posedge prog_clock or negedge reset_N) begin
        if (!reset_N) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_prAdrs   <= '0;
            r_lastAdrs <= '0;
            r_outValid <= 1'b0;
            r_outAdrs  <= '0;
            r_outData  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_prAdrs   <= start_adrs;
                        r_lastAdrs <= last_adrs;
                        r_cnt      <= LATENCY;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        r_outValid <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (r_cnt == 3'd1) begin
                        r_outData  <= mm_data;
                        r_outAdrs  <= r_prAdrs;
                        r_outValid <= 1'b1;
                        r_state    <= S_OUT;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_OUT: begin
                    if (abort) begin
                        r_outValid <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (r_outValid && out_ready) begin
                        r_outValid <= 1'b0;
                        if (r_prAdrs == r_lastAdrs) begin
                            r_state <= S_DONE;
                        end else begin
                            r_prAdrs <= r_prAdrs + ADRS_ONE;
                            r_cnt    <= LATENCY;
                            r_state  <= S_WAIT;
                        end
                    end
                end
                default: begin
                    r_outValid <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
